// File: rtl/draw_scheduler.sv
// Sprite draw scheduler: round-robin arbitration of three sprite requesters onto
// three drawers, with a setup delay, per-draw pixel counting, a timeout abort and
// a muxed VGA write port driven from the granted drawer.
module draw_scheduler #(
  parameter int unsigned NPIX    = 400,
  parameter int unsigned SETUP   = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [2:0]  draw_done,
  input  logic [26:0] px_colour,
  input  logic [23:0] px_x,
  input  logic [20:0] px_y,
  output logic [2:0]  draw_enable,
  output logic [7:0]  origin_x,
  output logic [6:0]  origin_y,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [8:0]  vga_colour,
  output logic        vga_plot,
  output logic [2:0]  ack,
  output logic        busy,
  output logic        abort
);

  localparam int unsigned SetupW = (SETUP > 1) ? $clog2(SETUP + 1) : 1;
  localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);

  localparam logic [SetupW-1:0] SetupMax = SetupW'(SETUP);
  localparam logic [8:0]        PixMax   = 9'(NPIX);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StDraw, StAck} state_e;

  state_e            state_q;
  logic [1:0]        win_q;
  logic [1:0]        ptr_q;
  logic [8:0]        pix_q;
  logic [SetupW-1:0] setup_q;
  logic [TmoW-1:0]   tmo_q;

  logic [1:0] pick;
  logic [7:0] pick_x;
  logic [6:0] pick_y;

  // Round-robin winner: search starts one past the last granted requester.
  always_comb begin
    pick = 2'd0;
    case (ptr_q)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Origin slices of the requester about to be granted.
  always_comb begin
    pick_x = 8'd0;
    pick_y = 7'd0;
    case (pick)
      2'd0:    begin pick_x = req_x[7:0];   pick_y = req_y[6:0];   end
      2'd1:    begin pick_x = req_x[15:8];  pick_y = req_y[13:7];  end
      2'd2:    begin pick_x = req_x[23:16]; pick_y = req_y[20:14]; end
      default: begin pick_x = 8'd0;         pick_y = 7'd0;         end
    endcase
  end

  assign busy     = (state_q != StIdle);
  // Plot only once setup has elapsed and until the sprite's pixel budget is used.
  assign vga_plot = (state_q == StDraw) && (setup_q == SetupMax) && (pix_q < PixMax);

  // VGA write port follows the granted drawer during DRAW and idles at zero otherwise.
  always_comb begin
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 9'd0;
    if (state_q == StDraw) begin
      case (win_q)
        2'd0: begin vga_x = px_x[7:0];   vga_y = px_y[6:0];   vga_colour = px_colour[8:0];   end
        2'd1: begin vga_x = px_x[15:8];  vga_y = px_y[13:7];  vga_colour = px_colour[17:9];  end
        2'd2: begin vga_x = px_x[23:16]; vga_y = px_y[20:14]; vga_colour = px_colour[26:18]; end
        default: begin vga_x = 8'd0; vga_y = 7'd0; vga_colour = 9'd0; end
      endcase
    end
  end

  // Scheduler FSM with registered grant, ack and abort outputs.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= StIdle;
      win_q       <= 2'd0;
      ptr_q       <= 2'd2;
      pix_q       <= 9'd0;
      setup_q     <= '0;
      tmo_q       <= '0;
      draw_enable <= 3'b000;
      origin_x    <= 8'd0;
      origin_y    <= 7'd0;
      ack         <= 3'b000;
      abort       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          ack   <= 3'b000;
          abort <= 1'b0;
          if (|req) begin
            win_q    <= pick;
            origin_x <= pick_x;
            origin_y <= pick_y;
            state_q  <= StGrant;
          end
        end
        StGrant: begin
          pix_q       <= 9'd0;
          setup_q     <= '0;
          tmo_q       <= '0;
          draw_enable <= 3'b001 << win_q;
          state_q     <= StDraw;
        end
        StDraw: begin
          if (setup_q != SetupMax) setup_q <= setup_q + SetupW'(1);
          if (vga_plot) pix_q <= pix_q + 9'd1;
          tmo_q <= tmo_q + TmoW'(1);
          // Normal completion wins over a timeout landing in the same cycle.
          if ((pix_q == PixMax) && draw_done[win_q]) begin
            draw_enable <= 3'b000;
            ack         <= 3'b001 << win_q;
            state_q     <= StAck;
          end else if (tmo_q == TmoLast) begin
            draw_enable <= 3'b000;
            abort       <= 1'b1;
            state_q     <= StAck;
          end
        end
        StAck: begin
          ack     <= 3'b000;
          abort   <= 1'b0;
          ptr_q   <= win_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter: NPIX, default 400, pixels per sprite (20x20).
REQ-002 Parameter: SETUP, default 3, cycles from drawer enable to first valid pixel.
REQ-003 Parameter: TIMEOUT, default 1023, max DRAW cycles before forced abort.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-high reset; asserted high clears all state immediately.
REQ-006 req  in  3  per-requester draw request, level, held until ack.
REQ-007 req_x  in  24  three 8-bit sprite origin X values; requester i at bits [8i+7:8i].
REQ-008 req_y  in  21  three 7-bit sprite origin Y values; requester i at bits [7i+6:7i].
REQ-009 draw_done  in  3  per-drawer completion flag.
REQ-010 px_colour  in  27  three 9-bit drawer colours.
REQ-011 px_x  in  24  three 8-bit drawer X outputs.
REQ-012 px_y  in  21  three 7-bit drawer Y outputs.
REQ-013 draw_enable  out  3  one-hot enable to granted drawer.
REQ-014 origin_x  out  8  latched origin X for granted drawer.
REQ-015 origin_y  out  7  latched origin Y for granted drawer.
REQ-016 vga_x  out  8  muxed pixel X to VGA write port.
REQ-017 vga_y  out  7  muxed pixel Y.
REQ-018 vga_colour  out  9  muxed pixel colour.
REQ-019 vga_plot  out  1  VGA write strobe.
REQ-020 ack  out  3  one-cycle completion pulse per requester.
REQ-021 busy  out  1  high in any state except IDLE.
REQ-022 abort  out  1  one-cycle pulse on timeout.

Function
REQ-023 FSM states IDLE, GRANT, DRAW, ACK; encoding free.
REQ-024 IDLE: any req bit set -> GRANT; round-robin pick, starting search one past last granted index (reset pointer = 2, so requester 0 wins first).
REQ-025 GRANT (1 cycle): latch winner index, origin_x/origin_y from winner's slice; clear pixel and timeout counters; -> DRAW.
REQ-026 DRAW: draw_enable[winner]=1, others 0; setup counter counts SETUP cycles with vga_plot=0.
REQ-027 After setup, vga_plot=1 every cycle until plotted-pixel counter reaches NPIX; counter width 9 bits; vga_x/y/colour = winner's px slices, combinational mux.
REQ-028 DRAW exits to ACK when pixel count == NPIX and draw_done[winner]=1 in same or later cycle; vga_plot=0 after NPIX plots even if draw_done late.
REQ-029 DRAW exits to ACK with abort pulse if timeout counter reaches TIMEOUT; ack not asserted for aborted request.
REQ-030 ACK (1 cycle): draw_enable all 0; ack[winner]=1 (unless aborted); update round-robin pointer to winner; -> IDLE.
REQ-031 A requester whose req drops during DRAW is still completed; ack still pulses.
REQ-032 req changes during GRANT/DRAW/ACK do not affect current grant; new requests wait for IDLE.
REQ-033 Simultaneous requests: exactly one grant; no requester starves; max wait two full draws.
REQ-034 vga_plot never high outside DRAW; draw_enable never has more than one bit set.
REQ-035 Outside DRAW, vga_x/vga_y/vga_colour drive 0.

Reset
REQ-036 On resetn high: state=IDLE, draw_enable=0, origin_x=0, origin_y=0, vga_plot=0, ack=0, abort=0, busy=0, counters=0, pointer=2.
REQ-037 Reset mid-DRAW: outputs drop asynchronously same instant; no ack or abort issued for interrupted request; request re-arbitrated after release.

Verification
REQ-038 Single req=001, req_x[7:0]=40, req_y[6:0]=30, drawer done after 400 pixels -> origin 40/30 in GRANT, plot low 3 cycles, exactly 400 plot cycles, ack=001 one cycle, busy low after.
REQ-039 req=111 held continuously -> grant order 0,1,2,0; each ack pulses once per draw.
REQ-040 req=010 dropped one cycle into DRAW -> draw completes, 400 plots, ack=010.
REQ-041 Drawer never asserts draw_done -> abort pulse after 1023 DRAW cycles, ack stays 000, returns to IDLE.
REQ-042 resetn pulsed after 100 plots -> all outputs 0 immediately, state IDLE, no ack; with req still high, new GRANT to same requester after release.
REQ-043 draw_done arriving 5 cycles after 400th plot -> plot low those 5 cycles, ack follows draw_done by one cycle.
